// File: rtl/axis_testpattern_sequencer.sv
// Frames an AXI-Stream test-pattern source into packets of cfg_packet_len beats, with an optional
// idle gap between packets and either a fixed packet count or continuous operation.
module axis_testpattern_sequencer #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned GAP_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_aresetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   cfg_packet_len,
  input  logic [CNT_WIDTH-1:0]   cfg_num_packets,
  input  logic [GAP_WIDTH-1:0]   cfg_gap_cycles,
  output logic                   gen_enable,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   pkt_count
);

  localparam logic [LEN_WIDTH-1:0] LenOne = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0] GapOne = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StStream, StGap, StFinish} state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] pkt_count_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] gap_cnt_q;
  logic                 stop_pending_q;

  logic                 streaming;
  logic                 at_last;
  logic                 beat;
  logic [CNT_WIDTH-1:0] pkt_next;

  // Outputs decode only registered state and the live handshake, so start/stop never reach AXIS.
  assign streaming     = (state_q == StStream);
  assign at_last       = (beat_cnt_q == len_q - LenOne);
  assign beat          = streaming & s_axis_tvalid & m_axis_tready;
  assign pkt_next      = pkt_count_q + CntOne;

  assign gen_enable    = streaming;
  assign s_axis_tready = streaming & m_axis_tready;
  assign m_axis_tvalid = streaming & s_axis_tvalid;
  assign m_axis_tdata  = streaming ? s_axis_tdata : '0;
  assign m_axis_tlast  = streaming & at_last;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFinish);
  assign pkt_count     = pkt_count_q;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q        <= StIdle;
      len_q          <= '0;
      num_q          <= '0;
      gap_q          <= '0;
      beat_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      pkt_count_q    <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop && (cfg_packet_len != '0)) begin
            len_q          <= cfg_packet_len;
            num_q          <= cfg_num_packets;
            gap_q          <= cfg_gap_cycles;
            pkt_count_q    <= '0;
            beat_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            stop_pending_q <= 1'b0;
            state_q        <= StStream;
          end
        end
        StStream: begin
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
          if (beat) begin
            if (at_last) begin
              beat_cnt_q  <= '0;
              gap_cnt_q   <= '0;
              pkt_count_q <= pkt_next;
              if (stop_pending_q || stop || ((num_q != '0) && (pkt_next == num_q))) begin
                state_q <= StFinish;
              end else if (gap_q != '0) begin
                state_q <= StGap;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + LenOne;
            end
          end
        end
        StGap: begin
          if (stop) begin
            state_q <= StFinish;
          end else if (gap_cnt_q == gap_q - GapOne) begin
            gap_cnt_q <= '0;
            state_q   <= StStream;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapOne;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/axis_testpattern_sequencer.md
Name: axis_testpattern_sequencer

Overview:
- Sequences an AXI-Stream test-pattern source into framed packets.
- Gates the source `enable`, passes beats through and inserts TLAST every `cfg_packet_len` beats.
- Runs `cfg_num_packets` packets, or runs continuously, with a programmable idle gap between packets.
- Sits between the counter test-pattern generator and downstream DMA/FIFO sinks; driven by a register bank or a testbench.

Parameters:
- TDATA_WIDTH, 32, width of the pass-through data path.
- LEN_WIDTH, 16, width of `cfg_packet_len` and of the beat counter.
- GAP_WIDTH, 16, width of `cfg_gap_cycles` and of the gap counter.
- CNT_WIDTH, 32, width of `cfg_num_packets` and `pkt_count`.

Ports:
- m_axis_aclk  in  1  sole clock; all logic on its rising edge.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; latches config and begins a run.
- stop  in  1  1-cycle pulse; graceful stop at the next packet boundary.
- cfg_packet_len  in  LEN_WIDTH  beats per packet; must be >=1.
- cfg_num_packets  in  CNT_WIDTH  packets per run; 0 = continuous.
- cfg_gap_cycles  in  GAP_WIDTH  idle cycles between packets.
- gen_enable  out  1  enable to the pattern generator.
- s_axis_tdata  in  TDATA_WIDTH  source data.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  source ready.
- m_axis_tdata  out  TDATA_WIDTH  sink data.
- m_axis_tvalid  out  1  sink valid.
- m_axis_tlast  out  1  end of packet.
- m_axis_tready  in  1  sink ready.
- busy  out  1  high when state != IDLE.
- done  out  1  1-cycle pulse when a run ends.
- pkt_count  out  CNT_WIDTH  packets completed in the current/last run.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - gen_enable, s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, done all 0.
  - pkt_count=0; beat, gap and stop_pending registers 0.
  - Reset mid-run aborts immediately; a partial packet is not terminated.
- States: IDLE, STREAM, GAP, FINISH.
- IDLE:
  - start=1 and cfg_packet_len!=0 → latch all three cfg_* inputs, clear pkt_count, beat_cnt=0, stop_pending=0, go to STREAM next cycle.
  - start with cfg_packet_len==0 is ignored.
  - start and stop in the same cycle → stop wins; remain IDLE.
  - cfg_* inputs are only sampled at the start pulse; later changes do not affect a run in progress.
- STREAM (combinational pass-through, zero latency):
  - m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tdata=s_axis_tdata.
  - m_axis_tlast=(beat_cnt==len-1).
  - gen_enable=1.
  - Beat = s_axis_tvalid & m_axis_tready; beat_cnt increments on each beat.
  - Last beat: beat_cnt←0 and pkt_count++, then next state:
    - FINISH if stop_pending, or a stop arrives this cycle, or (num!=0 and pkt_count+1==num);
    - else GAP if gap!=0;
    - else STREAM (back-to-back packets).
- stop in STREAM sets stop_pending; the current packet completes with TLAST.
- GAP:
  - All handshake outputs 0 and gen_enable=0; gap_cnt counts gap cycles.
  - After exactly gap cycles in GAP → STREAM.
  - stop in GAP → FINISH next cycle.
- FINISH: outputs 0; done=1 for this one cycle; → IDLE.
- busy=1 in STREAM, GAP and FINISH.
- start while busy is ignored.
- pkt_count holds its value in IDLE until the next accepted start.
- Wrap and limits:
  - beat_cnt never exceeds len-1.
  - pkt_count wraps modulo 2^CNT_WIDTH in continuous mode.
  - A full-scale cfg_packet_len (all ones) is legal.
- TLAST, valid and data change only when the source or sink changes, or on a state edge; no combinational path from start/stop to the AXIS outputs.

Test Plan:
1. len=4, num=2, gap=0, sink always ready, source counting 0.. → beats 0-7, TLAST on 3 and 7; done pulses 1 cycle after beat 7; pkt_count=2; busy returns to 0.
2. len=3, num=2, gap=5 → exactly 5 idle cycles between beat 2 (TLAST) and beat 3, with gen_enable=0 in those cycles; done after beat 5.
3. len=8, num=0, stop pulsed during beat 2 of packet 3 → packet 3 completes to TLAST (beat 7), FINISH, done; pkt_count=3; no further beats.
4. len=4, num=1, m_axis_tready toggled 1,0,0,1,... → no beat lost or duplicated; data/tvalid stable while stalled; TLAST only on the 4th accepted beat.
5. start with len=0 → stays IDLE, busy=0. Start+stop in the same cycle → IDLE. Start while busy → ignored; cfg changed mid-run → no effect.
6. Reset asserted mid-packet (beat 2 of 4) → all outputs 0 immediately. After release, start len=2, num=1 → clean 2-beat packet with pkt_count=1.
